// File: rtl/mul_pp_final_add.sv
// Final stage of the pipelined 64x64 multiplier: compresses the level-3 CSA rows plus the
// optional sign-correction row, then resolves the product through a split carry-propagate adder.
module mul_pp_final_add #(
  parameter int DataWidth = 64,
  parameter int W30       = 80,
  parameter int W31       = 64,
  parameter int SHIFT31   = 64
) (
  input  logic                   Clk,
  input  logic                   Rst,
  input  logic [1:0]             MulHoldFlagFromEx,
  input  logic [W30-1:0]         SumPP_CSA30,
  input  logic [W30-1:0]         CarryPP_CSA30,
  input  logic [W31-1:0]         SumPP_CSA31,
  input  logic [W31-1:0]         CarryPP_CSA31,
  input  logic                   Mulitiplier_63,
  input  logic [DataWidth-1:0]   CorrPP,
  output logic [2*DataWidth-1:0] Sum,
  output logic                   MulHoldEndToEx
);

  localparam int PW = 2 * DataWidth;

  function automatic logic [PW-1:0] csaSum(input logic [PW-1:0] a, input logic [PW-1:0] b,
                                           input logic [PW-1:0] c);
    return a ^ b ^ c;
  endfunction

  // Carry row is pre-shifted into its product weight; bits past the top are dropped.
  function automatic logic [PW-1:0] csaCarry(input logic [PW-1:0] a, input logic [PW-1:0] b,
                                             input logic [PW-1:0] c);
    return ((a & b) | (a & c) | (b & c)) << 1;
  endfunction

  logic [1:0]           flagR;
  logic                 launch;
  logic                 cancel;

  logic [PW-1:0]        row30S, row30C, row31S, row31C, corrRow;
  logic [PW-1:0]        s1, c1, s2, c2, sumANext, carryANext;
  logic [PW-1:0]        sumAR, carryAR;
  logic                 validAR;

  logic [DataWidth:0]   lowAdd;
  logic [DataWidth-1:0] lowBR, sumHighBR, carryHighBR;
  logic                 coutBR;
  logic                 validBR;

  logic [DataWidth-1:0] highAdd;
  logic [PW-1:0]        sumR;
  logic                 endR;

  // Launch on a nonzero flag that differs from last cycle; a zero flag cancels in-flight work.
  always_comb begin
    launch = (MulHoldFlagFromEx != 2'b00) && (MulHoldFlagFromEx != flagR);
    cancel = (MulHoldFlagFromEx == 2'b00);
  end

  // Align the four CSA rows and the correction row, then reduce them with 4:2 + 3:2 compression.
  always_comb begin
    row30S = {PW{1'b0}};
    row30C = {PW{1'b0}};
    row31S = {PW{1'b0}};
    row31C = {PW{1'b0}};
    row30S[W30-1:0] = SumPP_CSA30;
    row30C[W30-1:0] = CarryPP_CSA30;
    row31S[SHIFT31 +: W31] = SumPP_CSA31;
    row31C[SHIFT31 +: W31] = CarryPP_CSA31;
    if (Mulitiplier_63) begin
      corrRow = {CorrPP, {DataWidth{1'b0}}};
    end else begin
      corrRow = {PW{1'b0}};
    end
    s1         = csaSum(row30S, row30C, row31S);
    c1         = csaCarry(row30S, row30C, row31S);
    s2         = csaSum(s1, c1, row31C);
    c2         = csaCarry(s1, c1, row31C);
    sumANext   = csaSum(s2, c2, corrRow);
    carryANext = csaCarry(s2, c2, corrRow);
  end

  // Low-half and high-half carry-propagate additions.
  always_comb begin
    lowAdd  = {1'b0, sumAR[DataWidth-1:0]} + {1'b0, carryAR[DataWidth-1:0]};
    highAdd = sumHighBR + carryHighBR + {{(DataWidth-1){1'b0}}, coutBR};
  end

  // Previous flag value for launch edge detection.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      flagR <= 2'b00;
    end else begin
      flagR <= MulHoldFlagFromEx;
    end
  end

  // Stage A: data is captured only on a launch so idle-cycle inputs never reach Sum.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      sumAR   <= {PW{1'b0}};
      carryAR <= {PW{1'b0}};
      validAR <= 1'b0;
    end else begin
      validAR <= launch;
      if (launch) begin
        sumAR   <= sumANext;
        carryAR <= carryANext;
      end
    end
  end

  // Stage B: resolve the low half, forward the high halves and the carry between them.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      lowBR       <= {DataWidth{1'b0}};
      sumHighBR   <= {DataWidth{1'b0}};
      carryHighBR <= {DataWidth{1'b0}};
      coutBR      <= 1'b0;
      validBR     <= 1'b0;
    end else begin
      validBR <= validAR && !cancel;
      if (validAR && !cancel) begin
        lowBR       <= lowAdd[DataWidth-1:0];
        coutBR      <= lowAdd[DataWidth];
        sumHighBR   <= sumAR[PW-1:DataWidth];
        carryHighBR <= carryAR[PW-1:DataWidth];
      end
    end
  end

  // Stage C: assemble the product and raise the one-cycle completion pulse.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      sumR <= {PW{1'b0}};
      endR <= 1'b0;
    end else begin
      endR <= validBR && !cancel;
      if (validBR && !cancel) begin
        sumR <= {highAdd, lowBR};
      end
    end
  end

  assign Sum            = sumR;
  assign MulHoldEndToEx = endR;

endmodule

// File: tb/tb_mul_pp_final_add.sv
// Directed bench for mul_pp_final_add: latency, product values, cancel, back-to-back and reset.
module tb_mul_pp_final_add;

  logic         Clk;
  logic         Rst;
  logic [1:0]   MulHoldFlagFromEx;
  logic [79:0]  SumPP_CSA30, CarryPP_CSA30;
  logic [63:0]  SumPP_CSA31, CarryPP_CSA31;
  logic         Mulitiplier_63;
  logic [63:0]  CorrPP;
  logic [127:0] Sum;
  logic         MulHoldEndToEx;

  int checks = 0;
  int passed = 0;
  int nPulse;
  int pulseAt [2];
  logic [127:0] sumAt [2];

  mul_pp_final_add dut (
    .Clk(Clk), .Rst(Rst), .MulHoldFlagFromEx(MulHoldFlagFromEx),
    .SumPP_CSA30(SumPP_CSA30), .CarryPP_CSA30(CarryPP_CSA30),
    .SumPP_CSA31(SumPP_CSA31), .CarryPP_CSA31(CarryPP_CSA31),
    .Mulitiplier_63(Mulitiplier_63), .CorrPP(CorrPP),
    .Sum(Sum), .MulHoldEndToEx(MulHoldEndToEx)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic drive(input logic [1:0] flag, input logic [79:0] s30, input logic [79:0] c30,
                       input logic [63:0] s31, input logic [63:0] c31,
                       input logic m63, input logic [63:0] corr);
    @(posedge Clk); #1;
    MulHoldFlagFromEx = flag;
    SumPP_CSA30 = s30; CarryPP_CSA30 = c30;
    SumPP_CSA31 = s31; CarryPP_CSA31 = c31;
    Mulitiplier_63 = m63; CorrPP = corr;
  endtask

  // Change only the flag; data goes to X so nothing sampled outside a launch can matter.
  task automatic setFlag(input logic [1:0] flag);
    @(posedge Clk); #1;
    MulHoldFlagFromEx = flag;
    SumPP_CSA30 = 'x; CarryPP_CSA30 = 'x;
    SumPP_CSA31 = 'x; CarryPP_CSA31 = 'x;
    Mulitiplier_63 = 1'bx; CorrPP = 'x;
  endtask

  // Watch n clock edges; record the edge index and Sum for the first two pulses.
  task automatic observe(input int n);
    nPulse = 0;
    pulseAt[0] = -1; pulseAt[1] = -1;
    sumAt[0] = '0;   sumAt[1] = '0;
    for (int i = 1; i <= n; i++) begin
      @(posedge Clk);
      @(negedge Clk);
      if (MulHoldEndToEx) begin
        if (nPulse < 2) begin
          pulseAt[nPulse] = i;
          sumAt[nPulse]   = Sum;
        end
        nPulse++;
      end
    end
  endtask

  initial begin
    // Reset with random inputs
    Rst = 1'b0;
    MulHoldFlagFromEx = 2'($urandom_range(1, 3));
    SumPP_CSA30 = {16'($urandom), 32'($urandom), 32'($urandom)};
    CarryPP_CSA30 = {16'($urandom), 32'($urandom), 32'($urandom)};
    SumPP_CSA31 = {32'($urandom), 32'($urandom)};
    CarryPP_CSA31 = {32'($urandom), 32'($urandom)};
    Mulitiplier_63 = 1'b1;
    CorrPP = {32'($urandom), 32'($urandom)};
    repeat (4) @(posedge Clk);
    @(negedge Clk);
    chk("reset_sum", Sum, 128'h0);
    chk("reset_end", {127'h0, MulHoldEndToEx}, 128'h0);
    MulHoldFlagFromEx = 2'b00;
    @(negedge Clk);
    Rst = 1'b1;
    observe(10);
    chk("idle_no_pulse", 128'(nPulse), 128'd0);

    // Basic product
    drive(2'b01, 80'h5, 80'h0, 64'h0, 64'h0, 1'b0, 64'h0);
    setFlag(2'b01);
    observe(2);
    chk("basic_npulse", 128'(nPulse), 128'd1);
    chk("basic_latency", 128'(pulseAt[0] + 1), 128'd3);
    chk("basic_sum", sumAt[0], 128'h5);
    observe(10);
    chk("hold_no_relaunch", 128'(nPulse), 128'd0);
    chk("hold_sum", Sum, 128'h5);

    // Carry across halves, launched by a change of nonzero code
    drive(2'b10, 80'hFFFF_FFFF_FFFF_FFFF, 80'h1, 64'h0, 64'h0, 1'b0, 64'h0);
    observe(3);
    chk("carry_npulse", 128'(nPulse), 128'd1);
    chk("carry_latency", 128'(pulseAt[0]), 128'd3);
    chk("carry_sum", sumAt[0], 128'h1_0000_0000_0000_0000);

    // Cancel one cycle after launch
    drive(2'b01, 80'h7, 80'h0, 64'h0, 64'h0, 1'b0, 64'h0);
    setFlag(2'b00);
    observe(6);
    chk("cancel_no_pulse", 128'(nPulse), 128'd0);
    chk("cancel_sum_kept", Sum, 128'h1_0000_0000_0000_0000);

    // Correction row plus CSA31 wraps the upper half to zero
    drive(2'b01, 80'h0, 80'h0, 64'h8000_0000_0000_0000, 64'h0, 1'b1, 64'h8000_0000_0000_0000);
    observe(3);
    chk("corr_npulse", 128'(nPulse), 128'd1);
    chk("corr_latency", 128'(pulseAt[0]), 128'd3);
    chk("corr_sum", sumAt[0], 128'h0);

    // Back-to-back launches: 3+4 and (1<<64)+9
    setFlag(2'b00);
    drive(2'b01, 80'h3, 80'h4, 64'h0, 64'h0, 1'b0, 64'h0);
    drive(2'b10, 80'h0, 80'h9, 64'h1, 64'h0, 1'b0, 64'h0);
    setFlag(2'b10);
    observe(5);
    chk("b2b_npulse", 128'(nPulse), 128'd2);
    chk("b2b_latency0", 128'(pulseAt[0] + 2), 128'd3);
    chk("b2b_latency1", 128'(pulseAt[1] + 2), 128'd4);
    chk("b2b_sum0", sumAt[0], 128'h7);
    chk("b2b_sum1", sumAt[1], 128'h1_0000_0000_0000_0009);

    // Reset pulsed one cycle after launch
    setFlag(2'b00);
    drive(2'b01, 80'h55, 80'h0, 64'h0, 64'h0, 1'b0, 64'h0);
    @(posedge Clk); #1;
    Rst = 1'b0;
    #1;
    chk("midrst_sum", Sum, 128'h0);
    MulHoldFlagFromEx = 2'b00;
    @(negedge Clk);
    Rst = 1'b1;
    observe(6);
    chk("midrst_no_pulse", 128'(nPulse), 128'd0);
    chk("midrst_sum_after", Sum, 128'h0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
